// File: rtl/vga_timing_rx.sv
// Recovers pixel X/Y plus line/sync/frame measurements from a pixel-synchronous HS/VS/BLANK stream, with mode lock.
// Latency: 2 clocks from pins to every output; no backpressure, one pixel accepted every clock.
module vga_timing_rx #(
  parameter int H_TOTAL_EXP = 800,
  parameter int V_TOTAL_EXP = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iHS,
  input  logic        iVS,
  input  logic        iBLANK,
  output logic [10:0] oCurrent_X,
  output logic [10:0] oCurrent_Y,
  output logic        oActive,
  output logic [10:0] oH_Total,
  output logic [10:0] oH_Sync_Width,
  output logic [10:0] oV_Total,
  output logic        oFrame_Start,
  output logic        oLocked,
  output logic        oError
);

  localparam logic [10:0] CNT_MAX = 11'h7ff;
  localparam logic [11:0] H_EXP   = 12'(H_TOTAL_EXP);
  localparam logic [11:0] V_EXP   = 12'(V_TOTAL_EXP);
  localparam logic [4:0]  LOCK_N  = 5'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEEK, MEASURE, LOCKED} state_t;

  logic        s_hs_q, s_vs_q, s_blank_q, p_hs_q, p_vs_q, p_blank_q;
  logic        s_hs_d, s_vs_d, s_blank_d, p_hs_d, p_vs_d, p_blank_d;
  logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [10:0] x_q, x_d, a_line_q, a_line_d, cur_y_q, cur_y_d;
  logic [10:0] h_total_q, h_total_d, hs_width_q, hs_width_d, v_total_q, v_total_d;
  logic        h_valid_q, h_valid_d, line_bad_q, line_bad_d;
  logic        active_q, active_d, frame_start_q, frame_start_d;

  state_t      state_q;
  logic [3:0]  good_cnt_q;
  logic        error_q;

  logic        hs_fall, hs_rise, vs_fall, act_rise, act_fall;
  logic        hs_lost, line_mismatch, frame_ok;
  logic [10:0] h_inc;
  logic [11:0] line_len, v_meas;

  always_comb begin
    hs_fall  = p_hs_q & ~s_hs_q;
    hs_rise  = ~p_hs_q & s_hs_q;
    vs_fall  = p_vs_q & ~s_vs_q;
    act_rise = ~p_blank_q & s_blank_q;
    act_fall = p_blank_q & ~s_blank_q;
    h_inc    = (h_cnt_q == CNT_MAX) ? CNT_MAX : h_cnt_q + 11'd1;
    line_len = {1'b0, h_cnt_q} + 12'd1;
    // An HS edge landing on the VS edge still belongs to the frame that is ending.
    v_meas   = {1'b0, v_cnt_q} + {11'd0, hs_fall};
    hs_lost  = ~hs_fall & (h_cnt_q == CNT_MAX - 11'd1);
    line_mismatch = hs_fall & h_valid_q & (line_len != H_EXP);
    frame_ok = ~(line_bad_q | line_mismatch) & (v_meas == V_EXP);
  end

  always_comb begin
    s_hs_d    = iHS;
    s_vs_d    = iVS;
    s_blank_d = iBLANK;
    p_hs_d    = s_hs_q;
    p_vs_d    = s_vs_q;
    p_blank_d = s_blank_q;

    h_cnt_d   = hs_fall ? 11'd0 : h_inc;
    h_valid_d = h_valid_q;
    if (hs_lost)
      h_valid_d = 1'b0;
    else if (hs_fall)
      h_valid_d = 1'b1;
    h_total_d  = (hs_fall && h_valid_q) ? line_len[10:0] : h_total_q;
    // h_cnt restarts at 0 the clock after the fall, so the low width is one more than h_cnt at the rise.
    hs_width_d = hs_rise ? h_inc : hs_width_q;

    v_cnt_d = v_cnt_q;
    if (vs_fall)
      v_cnt_d = 11'd0;
    else if (hs_fall && v_cnt_q != CNT_MAX)
      v_cnt_d = v_cnt_q + 11'd1;
    v_total_d = v_total_q;
    if (vs_fall)
      v_total_d = v_meas[11] ? CNT_MAX : v_meas[10:0];

    line_bad_d = line_bad_q;
    if (vs_fall)
      line_bad_d = 1'b0;
    else if (line_mismatch)
      line_bad_d = 1'b1;

    x_d = 11'd0;
    if (act_rise)
      x_d = 11'd0;
    else if (s_blank_q && p_blank_q)
      x_d = x_q + 11'd1;

    a_line_d = a_line_q;
    if (vs_fall)
      a_line_d = 11'd0;
    else if (act_fall && a_line_q != CNT_MAX)
      a_line_d = a_line_q + 11'd1;

    cur_y_d       = s_blank_q ? a_line_q : 11'd0;
    active_d      = s_blank_q;
    frame_start_d = vs_fall;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s_hs_q        <= 1'b1;
      s_vs_q        <= 1'b1;
      s_blank_q     <= 1'b0;
      p_hs_q        <= 1'b1;
      p_vs_q        <= 1'b1;
      p_blank_q     <= 1'b0;
      h_cnt_q       <= 11'd0;
      v_cnt_q       <= 11'd0;
      x_q           <= 11'd0;
      a_line_q      <= 11'd0;
      cur_y_q       <= 11'd0;
      h_total_q     <= 11'd0;
      hs_width_q    <= 11'd0;
      v_total_q     <= 11'd0;
      h_valid_q     <= 1'b0;
      line_bad_q    <= 1'b0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      s_hs_q        <= s_hs_d;
      s_vs_q        <= s_vs_d;
      s_blank_q     <= s_blank_d;
      p_hs_q        <= p_hs_d;
      p_vs_q        <= p_vs_d;
      p_blank_q     <= p_blank_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      x_q           <= x_d;
      a_line_q      <= a_line_d;
      cur_y_q       <= cur_y_d;
      h_total_q     <= h_total_d;
      hs_width_q    <= hs_width_d;
      v_total_q     <= v_total_d;
      h_valid_q     <= h_valid_d;
      line_bad_q    <= line_bad_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Lock tracking; losing HS overrides everything and restarts the search.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= SEEK;
      good_cnt_q <= 4'd0;
      error_q    <= 1'b0;
    end else begin
      error_q <= 1'b0;
      if (hs_lost) begin
        state_q    <= SEEK;
        good_cnt_q <= 4'd0;
        error_q    <= 1'b1;
      end else begin
        case (state_q)
          SEEK: begin
            if (vs_fall) begin
              state_q    <= MEASURE;
              good_cnt_q <= 4'd0;
            end
          end
          MEASURE: begin
            if (vs_fall) begin
              if (frame_ok) begin
                good_cnt_q <= good_cnt_q + 4'd1;
                if ({1'b0, good_cnt_q} + 5'd1 == LOCK_N)
                  state_q <= LOCKED;
              end else begin
                good_cnt_q <= 4'd0;
                error_q    <= 1'b1;
              end
            end
          end
          LOCKED: begin
            if (line_mismatch || (vs_fall && v_meas != V_EXP)) begin
              state_q    <= MEASURE;
              good_cnt_q <= 4'd0;
              error_q    <= 1'b1;
            end
          end
          default: state_q <= SEEK;
        endcase
      end
    end
  end

  assign oCurrent_X    = x_q;
  assign oCurrent_Y    = cur_y_q;
  assign oActive       = active_q;
  assign oH_Total      = h_total_q;
  assign oH_Sync_Width = hs_width_q;
  assign oV_Total      = v_total_q;
  assign oFrame_Start  = frame_start_q;
  assign oLocked       = (state_q == LOCKED);
  assign oError        = error_q;

endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed bench for vga_timing_rx on a reduced video mode: 50 clocks x 24 lines,
// 6-clock HS, 32x16 active, VS low on lines 18-19 starting with that line's HS fall.
module tb_vga_timing_rx;

  localparam int H_TOT  = 50;
  localparam int HS_W   = 6;
  localparam int ACT_ST = 10;
  localparam int ACT_W  = 32;
  localparam int V_TOT  = 24;
  localparam int V_ACT  = 16;
  localparam int VS_LN  = 18;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        iHS, iVS, iBLANK;
  logic [10:0] oCurrent_X, oCurrent_Y, oH_Total, oH_Sync_Width, oV_Total;
  logic        oActive, oFrame_Start, oLocked, oError;
  logic [58:0] all_out;

  always #5 iCLK = ~iCLK;

  vga_timing_rx #(
    .H_TOTAL_EXP(H_TOT),
    .V_TOTAL_EXP(V_TOT),
    .LOCK_FRAMES(2)
  ) dut (
    .iCLK(iCLK),
    .iRST_N(iRST_N),
    .iHS(iHS),
    .iVS(iVS),
    .iBLANK(iBLANK),
    .oCurrent_X(oCurrent_X),
    .oCurrent_Y(oCurrent_Y),
    .oActive(oActive),
    .oH_Total(oH_Total),
    .oH_Sync_Width(oH_Sync_Width),
    .oV_Total(oV_Total),
    .oFrame_Start(oFrame_Start),
    .oLocked(oLocked),
    .oError(oError)
  );

  assign all_out = {oCurrent_X, oCurrent_Y, oActive, oH_Total, oH_Sync_Width,
                    oV_Total, oFrame_Start, oLocked, oError};

  int   checks, errors;
  int   cyc, err_cnt, fs_cnt, rise_fs, last_err_cyc, lock_fall_cyc;
  int   xy_bad, act_seen, max_x, max_y;
  int   stretch_ln, rel_ln, rel_px, base, t_fall;
  logic rise_with_fs, prev_locked, xy_en;
  int   p1_x, p1_y, p2_x, p2_y;
  logic p1_a, p2_a, p1_v, p2_v;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pixel clock: sample outputs (they reflect the pixel driven two steps ago), then drive the next pixel.
  task automatic step(input logic hs, input logic vs, input logic bl, input int ex, input int ey);
    @(posedge iCLK);
    #1;
    cyc++;
    if (oError === 1'b1) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (oFrame_Start === 1'b1) fs_cnt++;
    if (oLocked === 1'b1 && prev_locked === 1'b0) begin
      rise_fs      = fs_cnt;
      rise_with_fs = oFrame_Start;
    end
    if (oLocked === 1'b0 && prev_locked === 1'b1) lock_fall_cyc = cyc;
    prev_locked = oLocked;
    if (p2_v) begin
      if (oCurrent_X !== 11'(p2_x) || oCurrent_Y !== 11'(p2_y) || oActive !== p2_a) xy_bad++;
      if (oActive === 1'b1) begin
        act_seen++;
        if (int'(oCurrent_X) > max_x) max_x = int'(oCurrent_X);
        if (int'(oCurrent_Y) > max_y) max_y = int'(oCurrent_Y);
      end
    end
    iHS    = hs;
    iVS    = vs;
    iBLANK = bl;
    p2_x = p1_x; p2_y = p1_y; p2_a = p1_a; p2_v = p1_v;
    p1_x = ex;   p1_y = ey;   p1_a = bl;   p1_v = xy_en;
  endtask

  task automatic gen_line(input int ln);
    int   len;
    logic hs, vs, bl;
    len = (ln == stretch_ln) ? H_TOT + 1 : H_TOT;
    for (int px = 0; px < len; px++) begin
      if (ln == rel_ln && px == rel_px) iRST_N = 1'b1;
      hs = (px >= HS_W);
      vs = !(ln == VS_LN || ln == VS_LN + 1);
      bl = (ln < V_ACT) && (px >= ACT_ST) && (px < ACT_ST + ACT_W);
      step(hs, vs, bl, bl ? px - ACT_ST : 0, bl ? ln : 0);
    end
  endtask

  task automatic gen_lines(input int first, input int last);
    for (int ln = first; ln <= last; ln++) gen_line(ln);
  endtask

  task automatic gen_frame(input int nlines);
    gen_lines(0, nlines - 1);
  endtask

  initial begin
    checks = 0; errors = 0;
    cyc = 0; err_cnt = 0; fs_cnt = 0; rise_fs = 0; last_err_cyc = 0; lock_fall_cyc = 0;
    xy_bad = 0; act_seen = 0; max_x = 0; max_y = 0;
    stretch_ln = -1; rel_ln = -1; rel_px = -1; base = 0; t_fall = 0;
    rise_with_fs = 1'b0; prev_locked = 1'b0; xy_en = 1'b0;
    p1_x = 0; p1_y = 0; p2_x = 0; p2_y = 0;
    p1_a = 1'b0; p2_a = 1'b0; p1_v = 1'b0; p2_v = 1'b0;
    iRST_N = 1'b0; iHS = 1'b1; iVS = 1'b1; iBLANK = 1'b0;

    repeat (3) @(posedge iCLK);
    #1;
    check("reset_outputs", 64'(all_out), 64'd0);
    iRST_N = 1'b1;

    // Clean stream from reset: lock on the third frame start.
    repeat (3) gen_frame(V_TOT);
    check("lock_rise_fs_count", 64'(rise_fs), 64'd3);
    check("lock_rise_with_fs", 64'(rise_with_fs), 64'd1);
    check("locked_after_3", 64'(oLocked), 64'd1);
    check("no_err_clean", 64'(err_cnt), 64'd0);
    check("h_total", 64'(oH_Total), 64'd50);
    check("hs_width", 64'(oH_Sync_Width), 64'd6);
    check("v_total", 64'(oV_Total), 64'd24);

    xy_en = 1'b1;
    gen_frame(V_TOT);
    xy_en = 1'b0;
    check("xy_mismatches", 64'(xy_bad), 64'd0);
    check("x_max", 64'(max_x), 64'd31);
    check("y_max", 64'(max_y), 64'd15);
    check("active_pixels", 64'(act_seen), 64'd512);

    // One line stretched to 51 clocks while locked.
    base = err_cnt;
    stretch_ln = 7;
    gen_lines(0, 7);
    stretch_ln = -1;
    t_fall = cyc + 1;
    gen_lines(8, 8);
    check("stretch_err_once", 64'(err_cnt - base), 64'd1);
    check("stretch_err_latency", 64'(last_err_cyc - t_fall), 64'd2);
    check("stretch_lock_drop_edge", 64'(lock_fall_cyc), 64'(last_err_cyc));
    check("stretch_h_total", 64'(oH_Total), 64'd51);
    check("stretch_unlocked", 64'(oLocked), 64'd0);
    gen_lines(9, V_TOT - 1);
    gen_frame(V_TOT);
    check("stretch_still_measuring", 64'(oLocked), 64'd0);
    gen_frame(V_TOT);
    check("stretch_relocked", 64'(oLocked), 64'd1);

    // Short frame (23 lines) while locked.
    base = err_cnt;
    gen_frame(V_TOT - 1);
    gen_lines(0, VS_LN);
    check("short_err", 64'(err_cnt - base), 64'd1);
    check("short_v_total", 64'(oV_Total), 64'd23);
    check("short_unlocked", 64'(oLocked), 64'd0);
    gen_lines(VS_LN + 1, V_TOT - 1);
    gen_frame(V_TOT);
    gen_frame(V_TOT);
    check("short_relocked", 64'(oLocked), 64'd1);
    check("short_v_total_back", 64'(oV_Total), 64'd24);
    check("short_err_total", 64'(err_cnt - base), 64'd1);

    // HS held high: one saturation error, back to search.
    base = err_cnt;
    repeat (3000) step(1'b1, 1'b1, 1'b0, 0, 0);
    check("hs_lost_err_once", 64'(err_cnt - base), 64'd1);
    check("hs_lost_unlocked", 64'(oLocked), 64'd0);
    gen_frame(V_TOT);
    gen_frame(V_TOT);
    check("hs_lost_not_yet", 64'(oLocked), 64'd0);
    gen_frame(V_TOT);
    check("hs_lost_relocked", 64'(oLocked), 64'd1);
    check("hs_lost_err_total", 64'(err_cnt - base), 64'd1);

    // Reset pulse in the middle of a frame, released mid-line.
    gen_lines(0, 9);
    base = err_cnt;
    iRST_N = 1'b0;
    rel_ln = 11;
    rel_px = 25;
    gen_lines(10, 10);
    check("midreset_outputs", 64'(all_out), 64'd0);
    gen_lines(11, V_TOT - 1);
    rel_ln = -1;
    gen_frame(V_TOT);
    check("midreset_not_yet", 64'(oLocked), 64'd0);
    gen_frame(V_TOT);
    check("midreset_locked", 64'(oLocked), 64'd1);
    check("midreset_no_err", 64'(err_cnt - base), 64'd0);
    check("midreset_h_total", 64'(oH_Total), 64'd50);
    check("midreset_hs_width", 64'(oH_Sync_Width), 64'd6);
    check("midreset_v_total", 64'(oV_Total), 64'd24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
